// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: pipeline, debug and memory signals of the dmem arbiter; stats ports exist only with DMEM_ARB_STATS_EN
interface dmem_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
);
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_ready;
    logic              stall_mem;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              owner;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]       stat_p_grants;
    logic [31:0]       stat_d_grants;
    logic [31:0]       stat_stall_cycles;
`endif
    modport slave (
        input  p_req, p_we, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, m_rdata,
        output p_rdata, p_ready, stall_mem, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, owner
`ifdef DMEM_ARB_STATS_EN
        , output stat_p_grants, stat_d_grants, stat_stall_cycles
`endif
    );
    modport master (
        output p_req, p_we, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  p_rdata, p_ready, stall_mem, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, owner
`ifdef DMEM_ARB_STATS_EN
        , input stat_p_grants, stat_d_grants, stat_stall_cycles
`endif
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the fixed-latency dmem between pipeline and debug with a starvation guard; DMEM_ARB_STATS_EN adds grant/stall counters
module dmem_arbiter #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 10,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t            r_state, w_next;
    logic              r_we, r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_p_rdata, r_d_rdata;
    logic [2:0]        r_cnt;
    logic [3:0]        r_starve;
    logic              w_grant, w_d_win, w_p_ready;
    assign w_grant   = (r_state == IDLE) && (bus.p_req || bus.d_req);
    assign w_d_win   = bus.d_req && (!bus.p_req || r_starve == 4'(STARVE_LIMIT));
    assign w_p_ready = (r_state == DONE) && !r_owner;
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    // next-state: one access walks IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_grant ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (r_cnt == 3'd1) ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end
    // outputs decoded from registered state and command; only stall_mem sees an input directly
    always_comb begin
        bus.m_en      = (r_state == ISSUE);
        bus.m_we      = (r_state == ISSUE) && r_we;
        bus.m_addr    = r_addr;
        bus.m_wdata   = r_wdata;
        bus.p_ready   = w_p_ready;
        bus.d_ack     = (r_state == DONE) && r_owner;
        bus.p_rdata   = r_p_rdata;
        bus.d_rdata   = r_d_rdata;
        bus.owner     = r_owner;
        bus.stall_mem = bus.p_req && !w_p_ready;
    end
    // command latch at grant, starvation tracking in IDLE, wait countdown and read capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_owner   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_starve  <= '0;
            r_p_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_d_win;
                r_we    <= w_d_win ? bus.d_we    : bus.p_we;
                r_addr  <= w_d_win ? bus.d_addr  : bus.p_addr;
                r_wdata <= w_d_win ? bus.d_wdata : bus.p_wdata;
            end
            if (r_state == IDLE)
                r_starve <= (!bus.d_req || w_d_win) ? 4'd0 : r_starve + 4'd1;
            if (r_state == ISSUE) r_cnt <= 3'(MEM_LAT);
            else if (r_state == WAIT) r_cnt <= r_cnt - 3'd1;
            if (r_state == WAIT && r_cnt == 3'd1) begin
                if (r_owner) r_d_rdata <= bus.m_rdata;
                else         r_p_rdata <= bus.m_rdata;
            end
        end
    end
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_stat_p, r_stat_d, r_stat_s;
    assign bus.stat_p_grants     = r_stat_p;
    assign bus.stat_d_grants     = r_stat_d;
    assign bus.stat_stall_cycles = r_stat_s;
    // wrapping grant and stall counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_p <= '0;
            r_stat_d <= '0;
            r_stat_s <= '0;
        end else begin
            if (w_grant && !w_d_win) r_stat_p <= r_stat_p + 32'd1;
            if (w_grant && w_d_win)  r_stat_d <= r_stat_d + 32'd1;
            if (bus.p_req && !w_p_ready) r_stat_s <= r_stat_s + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with a transaction-level arbitration model and a fixed-latency memory
module tb_dmem_arbiter;
    localparam int L = 2;
    localparam int S = 4;
    typedef struct {logic we; logic [9:0] addr; logic [63:0] wd; logic own; int cyc;} cmd_t;
    typedef struct {logic we; logic [63:0] data; int cyc;} resp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int errors = 0;
    int cyc = 0;
    dmem_arbiter_if #(.DATA_W(64), .ADDR_W(10)) bus();
    dmem_arbiter #(.DATA_W(64), .ADDR_W(10), .MEM_LAT(L), .STARVE_LIMIT(S)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_val(input int i);
        return (i == 5) ? 64'hDEAD : {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'h5A5A5A5A};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory under the arbiter: write at strobe, read data appears L cycles after the strobe cycle
    logic [63:0] mem [1024];
    logic [63:0] pipe [L];
    logic minit = 1'b0;
    assign bus.m_rdata = pipe[L-1];
    always @(posedge clk) begin
        if (!minit) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            minit <= 1'b1;
        end else if (bus.m_en && bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
        if (bus.m_en) pipe[0] <= mem[bus.m_addr];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    // reference: serialized accesses, each occupying the port L+3 cycles, grants decided in idle cycles
    logic [63:0] ref_mem [1024];
    logic rinit = 1'b0;
    cmd_t cq[$];
    resp_t pq[$];
    resp_t dq[$];
    int busy, starve, pg, dg;
    always @(posedge clk or posedge rst) begin
        if (!rinit) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
            rinit = 1'b1;
        end
        if (rst) begin
            busy = 0; starve = 0; pg = 0; dg = 0;
            cq.delete(); pq.delete(); dq.delete();
        end else if (busy > 0) busy--;
        else begin
            if (!bus.d_req) starve = 0;
            if (bus.p_req || bus.d_req) begin
                automatic logic dw = bus.d_req && (!bus.p_req || starve == S);
                automatic cmd_t c;
                automatic resp_t r;
                c.we = dw ? bus.d_we : bus.p_we;
                c.addr = dw ? bus.d_addr : bus.p_addr;
                c.wd = dw ? bus.d_wdata : bus.p_wdata;
                c.own = dw;
                c.cyc = cyc + 1;
                cq.push_back(c);
                r.we = c.we;
                r.data = ref_mem[c.addr];
                r.cyc = cyc + L + 2;
                if (dw) dq.push_back(r); else pq.push_back(r);
                if (c.we) ref_mem[c.addr] = c.wd;
                if (dw) begin starve = 0; dg++; end
                else begin
                    pg++;
                    if (bus.d_req && starve < S) starve++;
                end
                busy = L + 2;
            end
        end
    end

    // monitor: pops expectations whenever the DUT strobes memory or completes an access
    int olog[$];
    int st_exp;
    logic exp_m, exp_p, exp_d;
    always @(negedge clk) begin
        if (rst) st_exp = 0;
        else begin
            exp_m = cq.size() > 0 && cq[0].cyc == cyc;
            exp_p = pq.size() > 0 && pq[0].cyc == cyc;
            exp_d = dq.size() > 0 && dq[0].cyc == cyc;
            if (bus.m_en || exp_m) begin
                chk("m_en", 64'(bus.m_en), 64'(exp_m));
                if (bus.m_en && exp_m) begin
                    automatic cmd_t c = cq.pop_front();
                    chk("m_addr", 64'(bus.m_addr), 64'(c.addr));
                    chk("m_we", 64'(bus.m_we), 64'(c.we));
                    chk("m_wdata", bus.m_wdata, c.wd);
                    chk("owner", 64'(bus.owner), 64'(c.own));
                    olog.push_back(int'(bus.owner));
                end
            end
            if (bus.p_ready || exp_p) begin
                chk("p_ready", 64'(bus.p_ready), 64'(exp_p));
                if (bus.p_ready && exp_p) begin
                    automatic resp_t r = pq.pop_front();
                    if (!r.we) chk("p_rdata", bus.p_rdata, r.data);
                end
            end
            if (bus.d_ack || exp_d) begin
                chk("d_ack", 64'(bus.d_ack), 64'(exp_d));
                if (bus.d_ack && exp_d) begin
                    automatic resp_t r = dq.pop_front();
                    if (!r.we) chk("d_rdata", bus.d_rdata, r.data);
                end
            end
            chk("stall_mem", 64'(bus.stall_mem), 64'(bus.p_req && !exp_p));
            if (bus.p_req && !exp_p) st_exp++;
        end
    end

    task automatic p_access(input logic we, input logic [9:0] a, input logic [63:0] wd);
        int n = 0;
        bus.p_req = 1'b1; bus.p_we = we; bus.p_addr = a; bus.p_wdata = wd;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.p_ready && n < 100);
        if (!bus.p_ready) begin
            errors++;
            $display("FAIL p_timeout: no p_ready for addr %0d within 100 cycles", a);
        end
    endtask

    task automatic d_access(input logic we, input logic [9:0] a, input logic [63:0] wd);
        int n = 0;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.d_ack && n < 100);
        if (!bus.d_ack) begin
            errors++;
            $display("FAIL d_timeout: no d_ack for addr %0d within 100 cycles", a);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_owners(input string name, input int exp[$]);
        chk({name, "_count"}, 64'(olog.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < olog.size(); i++) chk(name, 64'(olog[i]), 64'(exp[i]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        idle_cycles(3);
        chk("rst_m_en", 64'(bus.m_en), 0);
        chk("rst_p_ready", 64'(bus.p_ready), 0);
        chk("rst_d_ack", 64'(bus.d_ack), 0);
        chk("rst_stall", 64'(bus.stall_mem), 0);
        chk("rst_owner", 64'(bus.owner), 0);
        chk("rst_p_rdata", bus.p_rdata, 0);
        rst = 1'b0;
        idle_cycles(2);
        p_access(1'b0, 10'd5, 64'd0);
        chk("load5", bus.p_rdata, 64'hDEAD);
        bus.p_req = 1'b0;
        idle_cycles(2);
        d_access(1'b1, 10'd3, 64'd42);
        bus.d_req = 1'b0;
        idle_cycles(1);
        p_access(1'b0, 10'd3, 64'd0);
        chk("load3_after_dstore", bus.p_rdata, 64'd42);
        bus.p_req = 1'b0;
        idle_cycles(2);
        olog.delete();
        fork
            begin p_access(1'b0, 10'd8, 64'd0); bus.p_req = 1'b0; end
            begin d_access(1'b0, 10'd9, 64'd0); bus.d_req = 1'b0; end
        join
        idle_cycles(2);
        chk_owners("simul_order", '{0, 1});
        olog.delete();
        fork
            begin d_access(1'b0, 10'd11, 64'd0); bus.d_req = 1'b0; end
            begin
                for (int i = 0; i < 6; i++) p_access(1'b0, 10'(20 + i), 64'd0);
                bus.p_req = 1'b0;
            end
        join
        idle_cycles(2);
        chk_owners("starve_order", '{0, 0, 0, 0, 1, 0, 0});
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 10'd7;
        idle_cycles(2);
        #2;
        rst = 1'b1;
        bus.p_req = 1'b0;
        #1;
        chk("midrst_m_en", 64'(bus.m_en), 0);
        chk("midrst_p_ready", 64'(bus.p_ready), 0);
        chk("midrst_stall", 64'(bus.stall_mem), 0);
        chk("midrst_m_addr", 64'(bus.m_addr), 0);
        chk("midrst_p_rdata", bus.p_rdata, 0);
        idle_cycles(3);
        chk("inrst_p_ready", 64'(bus.p_ready), 0);
        rst = 1'b0;
        idle_cycles(1);
        p_access(1'b0, 10'd7, 64'd0);
        chk("load7_after_rst", bus.p_rdata, init_val(7));
        bus.p_req = 1'b0;
        idle_cycles(2);
        fork
            begin
                repeat (60) begin
                    p_access(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), {$urandom, $urandom});
                    if ($urandom_range(0, 2) == 0) begin
                        bus.p_req = 1'b0;
                        idle_cycles($urandom_range(0, 3));
                    end
                end
                bus.p_req = 1'b0;
            end
            begin
                repeat (30) begin
                    d_access(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), {$urandom, $urandom});
                    bus.d_req = 1'b0;
                    idle_cycles($urandom_range(0, 6));
                end
            end
        join
        idle_cycles(10);
        chk("cq_drained", 64'(cq.size()), 0);
        chk("pq_drained", 64'(pq.size()), 0);
        chk("dq_drained", 64'(dq.size()), 0);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_p_grants", 64'(bus.stat_p_grants), 64'(pg));
        chk("stat_d_grants", 64'(bus.stat_d_grants), 64'(dg));
        chk("stat_stall_cycles", 64'(bus.stat_stall_cycles), 64'(st_exp));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end
endmodule
